// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster generator.
package vga_pkg;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz (40 MHz pixel clock)
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    // Total counts per axis: active + front porch + sync + back porch.
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA640_H_TOTAL = vga_total(VGA640_H_ACTIVE, VGA640_H_FP,
                                              VGA640_H_SYNC, VGA640_H_BP);
    localparam int VGA640_V_TOTAL = vga_total(VGA640_V_ACTIVE, VGA640_V_FP,
                                              VGA640_V_SYNC, VGA640_V_BP);
    localparam int VGA800_H_TOTAL = vga_total(VGA800_H_ACTIVE, VGA800_H_FP,
                                              VGA800_H_SYNC, VGA800_H_BP);
    localparam int VGA800_V_TOTAL = vga_total(VGA800_V_ACTIVE, VGA800_V_FP,
                                              VGA800_V_SYNC, VGA800_V_BP);

    // Single-bit level outputs, registered together.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
    } vga_lvl_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and active decode.
// The count, sync level and active flag are combinational views of the
// current count; the top registers them.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter int   W      = 10,
    parameter logic POL    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         sync_o,
    output logic         active_o
);

    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_last;
    logic         in_sync;

    assign at_last = (count_q == LAST);

    // Advance on enable, wrapping from the terminal count back to zero.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_sync  = (count_q >= SYNC_LO) && (count_q < SYNC_HI);
    assign count_o  = count_q;
    assign wrap_o   = en_i && at_last;
    assign sync_o   = in_sync ? POL : ~POL;
    assign active_o = (count_q < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a movable pixel window.
// Two axis counters drive a single output register stage; every output
// describes the counter state held during the previous i_ce cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   WIN_X0   = 192,
    parameter int   WIN_Y0   = 112,
    parameter int   WIN_W    = 256,
    parameter int   WIN_H    = 256,
    parameter int   XW       = 10,
    parameter int   YW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic          o_win,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_pix_valid,
    output logic          o_sof,
    output logic          o_sol
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
            $error("vga_timing_gen: porch and sync widths must be non-zero");
        end
        if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE) begin : g_bad_win
            $error("vga_timing_gen: window exceeds the active area");
        end
        if (H_TOTAL - 1 >= (1 << XW) || V_TOTAL - 1 >= (1 << YW)) begin : g_bad_width
            $error("vga_timing_gen: XW/YW too narrow for the total counts");
        end
    endgenerate

    localparam logic [XW-1:0] X_LO = XW'(WIN_X0);
    localparam logic [XW-1:0] X_HI = XW'(WIN_X0 + WIN_W);
    localparam logic [YW-1:0] Y_LO = YW'(WIN_Y0);
    localparam logic [YW-1:0] Y_HI = YW'(WIN_Y0 + WIN_H);

    localparam vga_lvl_t LVL_RST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, win: 1'b0};

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap, v_wrap;
    logic          h_sync, v_sync;
    logic          h_act, v_act;
    logic          in_win;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (XW),
        .POL    (HS_POL)
    ) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (i_ce),
        .count_o  (h_cnt),
        .wrap_o   (h_wrap),
        .sync_o   (h_sync),
        .active_o (h_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (YW),
        .POL    (VS_POL)
    ) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (h_wrap),
        .count_o  (v_cnt),
        .wrap_o   (v_wrap),
        .sync_o   (v_sync),
        .active_o (v_act)
    );

    assign in_win = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                    (v_cnt >= Y_LO) && (v_cnt < Y_HI);

    vga_lvl_t      lvl_q, lvl_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          pv_q, pv_d;
    logic          sof_q, sof_d;
    logic          sol_q, sol_d;
    // High while the counters sit on pixel (0,0); set by reset and by the
    // wrap out of the last pixel of a frame, so no wide compare is needed.
    logic          first_q, first_d;

    // Capture the pixel described by the current counters on each i_ce;
    // levels hold and strobes drop when i_ce is low.
    always_comb begin
        lvl_d   = lvl_q;
        x_d     = x_q;
        y_d     = y_q;
        pv_d    = 1'b0;
        sof_d   = 1'b0;
        sol_d   = 1'b0;
        first_d = first_q;
        if (i_ce) begin
            lvl_d.hs  = h_sync;
            lvl_d.vs  = v_sync;
            lvl_d.de  = h_act && v_act;
            lvl_d.win = in_win;
            x_d       = in_win ? (h_cnt - X_LO) : '0;
            y_d       = in_win ? (v_cnt - Y_LO) : '0;
            pv_d      = 1'b1;
            sof_d     = first_q;
            sol_d     = (h_cnt == '0);
            first_d   = v_wrap;
        end
    end

    // Output register stage; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= LVL_RST;
            x_q     <= '0;
            y_q     <= '0;
            pv_q    <= 1'b0;
            sof_q   <= 1'b0;
            sol_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            lvl_q   <= lvl_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pv_q    <= pv_d;
            sof_q   <= sof_d;
            sol_q   <= sol_d;
            first_q <= first_d;
        end
    end

    assign o_hs        = lvl_q.hs;
    assign o_vs        = lvl_q.vs;
    assign o_de        = lvl_q.de;
    assign o_win       = lvl_q.win;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_pix_valid = pv_q;
    assign o_sof       = sof_q;
    assign o_sol       = sol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole
// frames fit in a short run. A second instance with inverted sync
// polarity runs in lockstep.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
    localparam int VA = 10, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;   // 25
    localparam int VT = VA + VFP + VSY + VBP;   // 15
    localparam int FRAME = HT * VT;             // 375
    localparam int X0 = 4, WW = 6, Y0 = 3, WH = 5;
    localparam int XW = 5, YW = 4;

    logic clk = 1'b0;
    logic rst;
    logic i_ce;

    logic a_hs, a_vs, a_de, a_win, a_pv, a_sof, a_sol;
    logic [XW-1:0] a_x;
    logic [YW-1:0] a_y;
    logic b_hs, b_vs, b_de, b_win, b_pv, b_sof, b_sol;
    logic [XW-1:0] b_x;
    logic [YW-1:0] b_y;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH),
        .XW(XW), .YW(YW)
    ) dut_a (
        .clk(clk), .rst(rst), .i_ce(i_ce),
        .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_win(a_win),
        .o_x(a_x), .o_y(a_y), .o_pix_valid(a_pv), .o_sof(a_sof), .o_sol(a_sol)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH),
        .XW(XW), .YW(YW)
    ) dut_b (
        .clk(clk), .rst(rst), .i_ce(i_ce),
        .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_win(b_win),
        .o_x(b_x), .o_y(b_y), .o_pix_valid(b_pv), .o_sof(b_sof), .o_sol(b_sol)
    );

    // {hs, vs, de, win, x[4:0], y[3:0], sof, sol}
    logic [14:0] vec_a, vec_b;
    assign vec_a = {a_hs, a_vs, a_de, a_win, a_x, a_y, a_sof, a_sol};
    assign vec_b = {b_hs, b_vs, b_de, b_win, b_x, b_y, b_sof, b_sol};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference raster for HS_POL = VS_POL = 0.
    function automatic logic [14:0] pix_vec(input int h, input int v);
        logic hs_in, vs_in, de, win;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        hs_in = (h >= HA + HFP) && (h < HA + HFP + HSY);
        vs_in = (v >= VA + VFP) && (v < VA + VFP + VSY);
        de    = (h < HA) && (v < VA);
        win   = (h >= X0) && (h < X0 + WW) && (v >= Y0) && (v < Y0 + WH);
        x     = win ? XW'(h - X0) : '0;
        y     = win ? YW'(v - Y0) : '0;
        return {~hs_in, ~vs_in, de, win, x, y, (h == 0 && v == 0), (h == 0)};
    endfunction

    logic [14:0] sb_q[$];
    int mh = 0, mv = 0;
    int cyc = 0;
    logic [12:0] prev_lvl;

    bit measure = 1'b0;
    int de_cnt = 0, win_cnt = 0, sof_cnt = 0, hs_low = 0;
    int last_sof = -1, last_sol = -1;
    bit line_seen = 1'b0, win_seen = 1'b0;
    logic [8:0] last_xy;

    task automatic step(input logic ce);
        logic [14:0] e;
        i_ce = ce;
        if (ce && !rst) begin
            sb_q.push_back(pix_vec(mh, mv));
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mh = 0;
            mv = 0;
            sb_q.delete();
            check_eq("rst_out_a", {vec_a, a_pv}, {15'h6000, 1'b0});
            check_eq("rst_out_b", {vec_b, b_pv}, {15'h0000, 1'b0});
        end else begin
            check_eq("pix_valid", {a_pv, b_pv}, {ce, ce});
            if (a_pv) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pix", vec_a, e);
                    check_eq("pix_pol", vec_b, e ^ 15'h6000);
                end
            end else begin
                check_eq("strobe_idle", {a_sof, a_sol, b_sof, b_sol}, 4'b0);
                check_eq("level_hold", vec_a[14:2], prev_lvl);
            end
            if (measure && a_pv) begin
                if (a_sof) begin
                    if (last_sof >= 0) check_eq("sof_period", cyc - last_sof, FRAME);
                    last_sof = cyc;
                    sof_cnt++;
                end
                if (a_sol) begin
                    if (last_sol >= 0) check_eq("sol_period", cyc - last_sol, HT);
                    last_sol = cyc;
                    if (line_seen) check_eq("hs_width", hs_low, HSY);
                    hs_low = 0;
                    line_seen = 1'b1;
                end
                if (!a_hs) hs_low++;
                if (a_de) de_cnt++;
                if (a_win) begin
                    if (!win_seen) check_eq("win_first_xy", {a_x, a_y}, 9'd0);
                    win_seen = 1'b1;
                    win_cnt++;
                    last_xy = {a_x, a_y};
                end
            end
        end
        prev_lvl = vec_a[14:2];
    endtask

    initial begin
        int guard;
        rst  = 1'b1;
        i_ce = 1'b0;

        check_eq("pkg_640_h_total", vga_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP), 800);
        check_eq("pkg_640_v_total", VGA640_V_TOTAL, 525);
        check_eq("pkg_800_h_total", vga_total(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP), 1056);
        check_eq("pkg_800_v_total", VGA800_V_TOTAL, 628);
        check_eq("pkg_800_vs_start", VGA800_V_ACTIVE + VGA800_V_FP, 601);

        // Reset with i_ce both low and high.
        step(1'b0);
        step(1'b1);
        step(1'b0);
        rst = 1'b0;

        // Two frames with i_ce tied high.
        measure = 1'b1;
        repeat (2 * FRAME) step(1'b1);
        measure = 1'b0;
        check_eq("sof_count", sof_cnt, 2);
        check_eq("de_count", de_cnt, 2 * HA * VA);
        check_eq("win_count", win_cnt, 2 * WW * WH);
        check_eq("win_last_xy", last_xy, {5'(WW - 1), 4'(WH - 1)});

        // One frame at a 1-in-4 enable rate.
        for (int i = 0; i < 4 * FRAME; i++) step(i % 4 == 0);

        // Irregular enable.
        repeat (600) step(1'($urandom_range(0, 1)));

        // Seek to mid-frame, then reset with i_ce high for 3 clocks.
        guard = 0;
        while (!(mh == 10 && mv == 6) && guard < 2 * FRAME) begin
            step(1'b1);
            guard++;
        end
        check_eq("seek_reached", (mh == 10 && mv == 6), 1);
        rst = 1'b1;
        repeat (3) step(1'b1);
        rst = 1'b0;
        step(1'b1);
        check_eq("sof_after_rst", {a_sof, a_sol}, 2'b11);
        repeat (200) step(1'($urandom_range(0, 1)));
        step(1'b0);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
